// File: rtl/wb_regfile_pkg.sv
// ============================================================================
// Module : wb_regfile_pkg
// Brief  : Mipu opcode encodings, register-file geometry and the writing-set
//          predicate shared by ID, the hazard unit and write-back.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package wb_regfile_pkg;

  localparam int c_OP_W   = 5;
  localparam int c_REG_AW = 3;
  localparam int c_NREG   = 8;

  // Pipeline run state
  localparam logic c_EXEC = 1'b1;
  localparam logic c_IDLE = 1'b0;

  localparam logic [c_OP_W-1:0] c_OP_NOP   = 5'b00000;
  localparam logic [c_OP_W-1:0] c_OP_HALT  = 5'b00001;
  localparam logic [c_OP_W-1:0] c_OP_LOAD  = 5'b00010;
  localparam logic [c_OP_W-1:0] c_OP_STORE = 5'b00011;
  localparam logic [c_OP_W-1:0] c_OP_SLL   = 5'b00100;
  localparam logic [c_OP_W-1:0] c_OP_SLA   = 5'b00101;
  localparam logic [c_OP_W-1:0] c_OP_SRL   = 5'b00110;
  localparam logic [c_OP_W-1:0] c_OP_SRA   = 5'b00111;
  localparam logic [c_OP_W-1:0] c_OP_ADD   = 5'b01000;
  localparam logic [c_OP_W-1:0] c_OP_ADDI  = 5'b01001;
  localparam logic [c_OP_W-1:0] c_OP_SUB   = 5'b01010;
  localparam logic [c_OP_W-1:0] c_OP_SUBI  = 5'b01011;
  localparam logic [c_OP_W-1:0] c_OP_CMP   = 5'b01100;
  localparam logic [c_OP_W-1:0] c_OP_AND   = 5'b01101;
  localparam logic [c_OP_W-1:0] c_OP_OR    = 5'b01110;
  localparam logic [c_OP_W-1:0] c_OP_XOR   = 5'b01111;
  localparam logic [c_OP_W-1:0] c_OP_LDIH  = 5'b10000;
  localparam logic [c_OP_W-1:0] c_OP_ADDC  = 5'b10001;
  localparam logic [c_OP_W-1:0] c_OP_SUBC  = 5'b10010;
  localparam logic [c_OP_W-1:0] c_OP_JUMP  = 5'b11000;
  localparam logic [c_OP_W-1:0] c_OP_JMPR  = 5'b11001;
  localparam logic [c_OP_W-1:0] c_OP_BZ    = 5'b11010;
  localparam logic [c_OP_W-1:0] c_OP_BNZ   = 5'b11011;
  localparam logic [c_OP_W-1:0] c_OP_BN    = 5'b11100;
  localparam logic [c_OP_W-1:0] c_OP_BNN   = 5'b11101;
  localparam logic [c_OP_W-1:0] c_OP_BC    = 5'b11110;
  localparam logic [c_OP_W-1:0] c_OP_BNC   = 5'b11111;

  // Opcodes that retire a result into gr[ir[10:8]]; everything else,
  // including undefined encodings, leaves the register file untouched.
  function automatic logic is_wb_op(input logic [c_OP_W-1:0] opcode);
    case (opcode)
      c_OP_LOAD, c_OP_LDIH,
      c_OP_ADD,  c_OP_ADDI, c_OP_ADDC,
      c_OP_SUB,  c_OP_SUBI, c_OP_SUBC,
      c_OP_AND,  c_OP_OR,   c_OP_XOR,
      c_OP_SLL,  c_OP_SRL,  c_OP_SLA, c_OP_SRA: is_wb_op = 1'b1;
      default:                                  is_wb_op = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_8x16.sv
// ============================================================================
// Module : regfile_8x16
// Brief  : Eight general registers, one write port, parallel read taps and a
//          combinational debug read mux.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_8x16
  import wb_regfile_pkg::*;
#(
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              i_we,
  input  logic [c_REG_AW-1:0]               i_waddr,
  input  logic [DATA_W-1:0]                 i_wdata,
  input  logic [c_REG_AW-1:0]               i_dbg_sel,
  output logic [c_NREG-1:0][DATA_W-1:0]     o_gr,
  output logic [DATA_W-1:0]                 o_dbg_data
);

  logic [c_NREG-1:0][DATA_W-1:0] r_gr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_NREG; i++) begin
        r_gr[i] <= RST_VAL;
      end
    end else if (i_we) begin
      r_gr[i_waddr] <= i_wdata;
    end
  end

  assign o_gr = r_gr;

  // Reads the stored value, so a register being written shows its old value.
  assign o_dbg_data = r_gr[i_dbg_sel];

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
// ============================================================================
// Module : wb_regfile
// Brief  : Mipu write-back stage register, commit control, HALT retirement
//          and the general register file read by ID.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              state,
  input  logic [15:0]       mem_ir,
  input  logic [DATA_W-1:0] mem_result,
  output logic [15:0]       wb_ir,
  output logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] gr0,
  output logic [DATA_W-1:0] gr1,
  output logic [DATA_W-1:0] gr2,
  output logic [DATA_W-1:0] gr3,
  output logic [DATA_W-1:0] gr4,
  output logic [DATA_W-1:0] gr5,
  output logic [DATA_W-1:0] gr6,
  output logic [DATA_W-1:0] gr7,
  output logic              wb_we,
  output logic              halted,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  logic [15:0]                   r_wb_ir;
  logic [DATA_W-1:0]             r_wb_result;
  logic                          r_halted;
  logic [c_OP_W-1:0]             w_opcode;
  logic                          w_run;
  logic                          w_we;
  logic [c_NREG-1:0][DATA_W-1:0] w_gr;

  assign w_opcode = r_wb_ir[15:11];
  assign w_run    = (state == c_EXEC) && !r_halted;
  assign w_we     = w_run && is_wb_op(w_opcode);

  // The commit below reads the outgoing wb_ir/wb_result on the same edge
  // that this register captures the next instruction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wb_ir     <= '0;
      r_wb_result <= '0;
      r_halted    <= 1'b0;
    end else if (w_run) begin
      r_wb_ir     <= mem_ir;
      r_wb_result <= mem_result;
      if (w_opcode == c_OP_HALT) begin
        r_halted <= 1'b1;
      end
    end
  end

  regfile_8x16 #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_rf (
    .clock      (clock),
    .reset      (reset),
    .i_we       (w_we),
    .i_waddr    (r_wb_ir[10:8]),
    .i_wdata    (r_wb_result),
    .i_dbg_sel  (dbg_sel),
    .o_gr       (w_gr),
    .o_dbg_data (dbg_data)
  );

  assign wb_ir     = r_wb_ir;
  assign wb_result = r_wb_result;
  assign wb_we     = w_we;
  assign halted    = r_halted;
  assign gr0       = w_gr[0];
  assign gr1       = w_gr[1];
  assign gr2       = w_gr[2];
  assign gr3       = w_gr[3];
  assign gr4       = w_gr[4];
  assign gr5       = w_gr[5];
  assign gr6       = w_gr[6];
  assign gr7       = w_gr[7];

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// Module : tb_wb_regfile
// Brief  : Directed self-checking bench for the write-back stage/register file.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_wb_regfile;

  logic        clock;
  logic        reset;
  logic        state;
  logic [15:0] mem_ir;
  logic [15:0] mem_result;
  logic [15:0] wb_ir;
  logic [15:0] wb_result;
  logic [15:0] gr0, gr1, gr2, gr3, gr4, gr5, gr6, gr7;
  logic        wb_we;
  logic        halted;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;
  logic [15:0] g [8];

  int checks   = 0;
  int failures = 0;

  wb_regfile #(.DATA_W(16), .RST_VAL(16'h0000)) dut (
    .clock      (clock),
    .reset      (reset),
    .state      (state),
    .mem_ir     (mem_ir),
    .mem_result (mem_result),
    .wb_ir      (wb_ir),
    .wb_result  (wb_result),
    .gr0        (gr0),
    .gr1        (gr1),
    .gr2        (gr2),
    .gr3        (gr3),
    .gr4        (gr4),
    .gr5        (gr5),
    .gr6        (gr6),
    .gr7        (gr7),
    .wb_we      (wb_we),
    .halted     (halted),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  assign g[0] = gr0;
  assign g[1] = gr1;
  assign g[2] = gr2;
  assign g[3] = gr3;
  assign g[4] = gr4;
  assign g[5] = gr5;
  assign g[6] = gr6;
  assign g[7] = gr7;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset      = 1'b0;
    state      = 1'b1;
    mem_ir     = 16'h0000;
    mem_result = 16'h0000;
    dbg_sel    = 3'd0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    state      = 1'b1;
    mem_ir     = 16'h0000;
    mem_result = 16'h0000;
    dbg_sel    = 3'd0;
    #12;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (g[i] !== 16'h0000) begin
        failures++;
        $display("FAIL reset_gr%0d got=%h exp=0000", i, g[i]);
      end
    end
    checks++;
    if (wb_ir !== 16'h0000 || wb_result !== 16'h0000 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_stage wb_ir=%h wb_result=%h halted=%b exp=0000/0000/0", wb_ir, wb_result, halted);
    end
    tick();
    reset = 1'b1;
    tick();
    // Commit ADD gr3 <- 1234, then assert reset between edges.
    mem_ir = 16'h4300; mem_result = 16'h1234;
    tick();
    mem_ir = 16'h0000; mem_result = 16'h0000;
    tick();
    checks++;
    if (gr3 !== 16'h1234) begin
      failures++;
      $display("FAIL reset_pre_gr3 got=%h exp=1234", gr3);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (gr3 !== 16'h0000) begin
      failures++;
      $display("FAIL reset_async_gr3 got=%h exp=0000", gr3);
    end
    reset = 1'b1;
    tick();
    // Pending write in WB is dropped by a reset pulse.
    mem_ir = 16'h4300; mem_result = 16'h1234;
    tick();
    mem_ir = 16'h0000; mem_result = 16'h0000;
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    tick();
    checks++;
    if (gr3 !== 16'h0000 || wb_ir !== 16'h0000) begin
      failures++;
      $display("FAIL reset_drop_pending gr3=%h wb_ir=%h exp=0000/0000", gr3, wb_ir);
    end
  endtask

  task automatic test_add();
    apply_reset();
    dbg_sel    = 3'd3;
    mem_ir     = 16'h4312;
    mem_result = 16'hBEEF;
    tick();
    mem_ir = 16'h0000; mem_result = 16'h0000;
    checks++;
    if (wb_ir !== 16'h4312) begin
      failures++;
      $display("FAIL add_wb_ir got=%h exp=4312", wb_ir);
    end
    checks++;
    if (wb_we !== 1'b1) begin
      failures++;
      $display("FAIL add_wb_we got=%b exp=1", wb_we);
    end
    checks++;
    if (dbg_data !== 16'h0000) begin
      failures++;
      $display("FAIL add_dbg_precommit got=%h exp=0000", dbg_data);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (g[i] !== ((i == 3) ? 16'hBEEF : 16'h0000)) begin
        failures++;
        $display("FAIL add_gr%0d got=%h exp=%h", i, g[i], (i == 3) ? 16'hBEEF : 16'h0000);
      end
    end
    checks++;
    if (dbg_data !== 16'hBEEF) begin
      failures++;
      $display("FAIL add_dbg_post got=%h exp=beef", dbg_data);
    end
  endtask

  task automatic test_non_writers();
    logic [15:0] nw_ir [3];
    logic [15:0] nw_res[3];
    nw_ir[0] = 16'h1A10; nw_res[0] = 16'h5555;
    nw_ir[1] = 16'h6012; nw_res[1] = 16'h5555;
    nw_ir[2] = 16'hD005; nw_res[2] = 16'h5555;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      mem_ir     = {5'b01000, 3'(i), 8'h00};
      mem_result = 16'hAAAA;
      tick();
    end
    mem_ir = 16'h0000; mem_result = 16'h0000;
    tick();
    for (int k = 0; k < 3; k++) begin
      mem_ir = nw_ir[k]; mem_result = nw_res[k];
      tick();
      checks++;
      if (wb_we !== 1'b0 || wb_ir !== nw_ir[k]) begin
        failures++;
        $display("FAIL nonwr_we_%0d wb_we=%b wb_ir=%h exp=0/%h", k, wb_we, wb_ir, nw_ir[k]);
      end
    end
    mem_ir = 16'h0000; mem_result = 16'h0000;
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (g[i] !== 16'hAAAA) begin
        failures++;
        $display("FAIL nonwr_gr%0d got=%h exp=aaaa", i, g[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    mem_ir = 16'h1500; mem_result = 16'h0001;
    tick();
    mem_ir = 16'h1500; mem_result = 16'h0002;
    tick();
    checks++;
    if (gr5 !== 16'h0001) begin
      failures++;
      $display("FAIL b2b_first gr5=%h exp=0001", gr5);
    end
    mem_ir = 16'h0000; mem_result = 16'h0000;
    tick();
    checks++;
    if (gr5 !== 16'h0002) begin
      failures++;
      $display("FAIL b2b_second gr5=%h exp=0002", gr5);
    end
  endtask

  task automatic test_stall();
    mem_ir = 16'h4F03; mem_result = 16'h0007;
    tick();
    mem_ir = 16'h0000; mem_result = 16'h0000;
    state  = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (wb_we !== 1'b0 || gr7 !== 16'hAAAA || wb_ir !== 16'h4F03) begin
        failures++;
        $display("FAIL stall_cyc%0d wb_we=%b gr7=%h wb_ir=%h exp=0/aaaa/4f03", c, wb_we, gr7, wb_ir);
      end
      tick();
    end
    checks++;
    if (gr7 !== 16'hAAAA) begin
      failures++;
      $display("FAIL stall_hold gr7=%h exp=aaaa", gr7);
    end
    state = 1'b1;
    #1;
    checks++;
    if (wb_we !== 1'b1) begin
      failures++;
      $display("FAIL stall_resume_we got=%b exp=1", wb_we);
    end
    tick();
    checks++;
    if (gr7 !== 16'h0007) begin
      failures++;
      $display("FAIL stall_commit gr7=%h exp=0007", gr7);
    end
  endtask

  task automatic test_halt();
    apply_reset();
    mem_ir = 16'h0800; mem_result = 16'h0000;
    tick();
    checks++;
    if (halted !== 1'b0 || wb_ir !== 16'h0800) begin
      failures++;
      $display("FAIL halt_inwb halted=%b wb_ir=%h exp=0/0800", halted, wb_ir);
    end
    mem_ir = 16'h4100; mem_result = 16'hFFFF;
    tick();
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL halt_set got=%b exp=1", halted);
    end
    mem_ir = 16'h4200; mem_result = 16'h1111;
    for (int c = 0; c < 3; c++) begin
      tick();
    end
    dbg_sel = 3'd1;
    #1;
    checks++;
    if (gr1 !== 16'h0000 || wb_we !== 1'b0) begin
      failures++;
      $display("FAIL halt_no_commit gr1=%h wb_we=%b exp=0000/0", gr1, wb_we);
    end
    checks++;
    if (wb_ir !== 16'h4100 || gr2 !== 16'h0000) begin
      failures++;
      $display("FAIL halt_frozen wb_ir=%h gr2=%h exp=4100/0000", wb_ir, gr2);
    end
    checks++;
    if (dbg_data !== 16'h0000 || halted !== 1'b1) begin
      failures++;
      $display("FAIL halt_dbg dbg_data=%h halted=%b exp=0000/1", dbg_data, halted);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_non_writers();
    test_back_to_back();
    test_stall();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
